// File: rtl/ac97_rx_deframer.sv
// AC-link receive deframer: aligns to ac97_sync, deserialises codec->controller frames and
// publishes TAG, register-read status (slots 1/2) and PCM capture (slots 3/4).
// Optional build macro AC97_RX_SLOTREQ_EN adds the slot_req[9:0] output (slot1[11:2]).
module ac97_rx_deframer #(
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        ac97_bitclk,
    input  logic        ac97_rst_b,
    input  logic        ac97_sdata_in,
    input  logic        ac97_sync,
    output logic        locked,
    output logic        sync_err,
    output logic        frame_strobe,
    output logic        codec_ready,
    output logic [11:0] tag_valid,
    output logic        status_valid,
    output logic [6:0]  status_addr,
    output logic [15:0] status_data,
`ifdef AC97_RX_SLOTREQ_EN
    output logic [9:0]  slot_req,
`endif
    output logic        pcm_valid,
    output logic [19:0] pcm_left,
    output logic [19:0] pcm_right
);

    localparam int unsigned FRAME_BITS = 256;
    localparam int unsigned SLOT_BITS  = 20;
    localparam int unsigned TAG_BITS   = 16;
    localparam int unsigned CNT_W      = 8;
    // Only the TAG and slots 1..4 carry information this block decodes.
    localparam int unsigned CAP_BITS   = TAG_BITS + 4 * SLOT_BITS;
    localparam int unsigned GOOD_W     = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(FRAME_BITS - 2);
    localparam logic [CNT_W-1:0]  CNT_CAP  = CNT_W'(CAP_BITS);
    localparam logic [GOOD_W:0]   LOCK_TGT = (GOOD_W + 1)'(LOCK_FRAMES);

    // Capture-register field positions (frame bit 0 lands in the MSB).
    localparam int unsigned S1_MSB = CAP_BITS - TAG_BITS - 1;
    localparam int unsigned S2_MSB = S1_MSB - SLOT_BITS;
    localparam int unsigned S3_MSB = S2_MSB - SLOT_BITS;
    localparam int unsigned S4_MSB = S3_MSB - SLOT_BITS;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [GOOD_W-1:0]   good_q;
    logic [GOOD_W-1:0]   good_d;
    logic [GOOD_W:0]     good_inc_c;
    logic                armed_q;
    logic                armed_d;
    logic                sdata_neg;
    logic                sync_q;
    logic [CAP_BITS-1:0] cap_q;
    logic                rise_c;
    logic                err_c;
    logic                publish_c;
    logic                cap_unused;

    logic [19:0] slot1_c;
    logic [19:0] slot2_c;
    logic [19:0] slot3_c;
    logic [19:0] slot4_c;
    logic        v_slot1_c;
    logic        v_slot2_c;
    logic        v_slot3_c;
    logic        v_slot4_c;

    assign rise_c     = ac97_sync & ~sync_q;
    assign good_inc_c = {1'b0, good_q} + (GOOD_W + 1)'(1);

    assign slot1_c    = cap_q[S1_MSB -: SLOT_BITS];
    assign slot2_c    = cap_q[S2_MSB -: SLOT_BITS];
    assign slot3_c    = cap_q[S3_MSB -: SLOT_BITS];
    assign slot4_c    = cap_q[S4_MSB -: SLOT_BITS];
    assign v_slot1_c  = cap_q[CAP_BITS - 2];
    assign v_slot2_c  = cap_q[CAP_BITS - 3];
    assign v_slot3_c  = cap_q[CAP_BITS - 4];
    assign v_slot4_c  = cap_q[CAP_BITS - 5];
    // TAG bits 2..0 and unused slot fields are intentionally dropped.
    assign cap_unused = ^cap_q;

    // Codec launches data on the rising edge, so sample it half a bit later.
    always_ff @(negedge ac97_bitclk or negedge ac97_rst_b) begin
        if (!ac97_rst_b) begin
            sdata_neg <= 1'b0;
        end else begin
            sdata_neg <= ac97_sdata_in;
        end
    end

    // State register, bit counter, sync history and capture shifter.
    always_ff @(posedge ac97_bitclk or negedge ac97_rst_b) begin
        if (!ac97_rst_b) begin
            state_q <= ST_UNLOCKED;
            cnt_q   <= '0;
            good_q  <= '0;
            armed_q <= 1'b0;
            sync_q  <= 1'b0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            good_q  <= good_d;
            armed_q <= armed_d;
            sync_q  <= ac97_sync;
            if (cnt_q < CNT_CAP) begin
                cap_q <= {cap_q[CAP_BITS-2:0], sdata_neg};
            end
        end
    end

    // Alignment FSM: next state, counter reload, lock qualification, publish decision.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        good_d    = good_q;
        armed_d   = armed_q;
        err_c     = 1'b0;
        publish_c = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                if (rise_c) begin
                    state_d = (LOCK_FRAMES <= 1) ? ST_LOCKED : ST_LOCKING;
                    cnt_d   = CNT_LAST;
                    good_d  = GOOD_W'(1);
                end
            end
            ST_LOCKING: begin
                if (rise_c) begin
                    if (cnt_q == CNT_PRE) begin
                        good_d = good_inc_c[GOOD_W-1:0];
                        if (good_inc_c >= LOCK_TGT) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        cnt_d  = CNT_LAST;
                        good_d = GOOD_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (rise_c && (cnt_q != CNT_PRE)) begin
                    err_c   = 1'b1;
                    state_d = ST_LOCKING;
                    cnt_d   = CNT_LAST;
                    good_d  = GOOD_W'(1);
                end else if (cnt_q == CNT_LAST) begin
                    // The first bit-255 seen after locking closes a partial frame; skip it.
                    publish_c = armed_q;
                    armed_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
            end
        endcase
        if (state_d != ST_LOCKED) begin
            armed_d = 1'b0;
        end
    end

    // Published outputs: pulses for one cycle, payloads hold between their pulses.
    always_ff @(posedge ac97_bitclk or negedge ac97_rst_b) begin
        if (!ac97_rst_b) begin
            locked       <= 1'b0;
            sync_err     <= 1'b0;
            frame_strobe <= 1'b0;
            codec_ready  <= 1'b0;
            tag_valid    <= '0;
            status_valid <= 1'b0;
            status_addr  <= '0;
            status_data  <= '0;
            pcm_valid    <= 1'b0;
            pcm_left     <= '0;
            pcm_right    <= '0;
        end else begin
            locked       <= (state_d == ST_LOCKED);
            sync_err     <= err_c;
            frame_strobe <= publish_c;
            status_valid <= publish_c & v_slot1_c & v_slot2_c;
            pcm_valid    <= publish_c & v_slot3_c & v_slot4_c;
            if (publish_c) begin
                codec_ready <= cap_q[CAP_BITS-1];
                tag_valid   <= cap_q[CAP_BITS-2 -: 12];
                if (v_slot1_c && v_slot2_c) begin
                    status_addr <= slot1_c[18:12];
                    status_data <= slot2_c[19:4];
                end
                if (v_slot3_c && v_slot4_c) begin
                    pcm_left  <= slot3_c;
                    pcm_right <= slot4_c;
                end
            end
        end
    end

`ifdef AC97_RX_SLOTREQ_EN
    // Codec slot-request flags (active low), refreshed whenever slot1 is tagged valid.
    always_ff @(posedge ac97_bitclk or negedge ac97_rst_b) begin
        if (!ac97_rst_b) begin
            slot_req <= 10'h3FF;
        end else if (publish_c && v_slot1_c) begin
            slot_req <= slot1_c[11:2];
        end
    end
`endif

endmodule

// File: tb/tb_ac97_rx_deframer.sv
// Scoreboard bench for ac97_rx_deframer: a frame-level model predicts lock state and published
// values from the sync waveform and slot contents; a monitor compares on every frame_strobe.
module tb_ac97_rx_deframer;

    localparam int LOCK_FRAMES = 2;

    logic        ac97_bitclk = 1'b0;
    logic        ac97_rst_b;
    logic        ac97_sdata_in;
    logic        ac97_sync;
    logic        locked;
    logic        sync_err;
    logic        frame_strobe;
    logic        codec_ready;
    logic [11:0] tag_valid;
    logic        status_valid;
    logic [6:0]  status_addr;
    logic [15:0] status_data;
    logic        pcm_valid;
    logic [19:0] pcm_left;
    logic [19:0] pcm_right;
`ifdef AC97_RX_SLOTREQ_EN
    logic [9:0]  slot_req;
`endif

    ac97_rx_deframer #(.LOCK_FRAMES(LOCK_FRAMES)) dut (
        .ac97_bitclk   (ac97_bitclk),
        .ac97_rst_b    (ac97_rst_b),
        .ac97_sdata_in (ac97_sdata_in),
        .ac97_sync     (ac97_sync),
        .locked        (locked),
        .sync_err      (sync_err),
        .frame_strobe  (frame_strobe),
        .codec_ready   (codec_ready),
        .tag_valid     (tag_valid),
        .status_valid  (status_valid),
        .status_addr   (status_addr),
        .status_data   (status_data),
`ifdef AC97_RX_SLOTREQ_EN
        .slot_req      (slot_req),
`endif
        .pcm_valid     (pcm_valid),
        .pcm_left      (pcm_left),
        .pcm_right     (pcm_right)
    );

    always #5 ac97_bitclk = ~ac97_bitclk;

    typedef struct {
        logic        codec_ready;
        logic [11:0] tag_valid;
        logic        status_valid;
        logic [6:0]  status_addr;
        logic [15:0] status_data;
        logic        pcm_valid;
        logic [19:0] pcm_left;
        logic [19:0] pcm_right;
        logic [9:0]  slot_req;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks       = 0;
    int failures     = 0;
    int exp_err_cnt  = 0;
    int seen_err_cnt = 0;

    // Frame-level reference state.
    longint      cyc       = 0;
    longint      last_rise = 0;
    bit          have_last = 0;
    int          run       = 0;
    bit          m_locked  = 0;
    bit          prev_sync = 0;
    bit          frame_err = 0;
    logic [6:0]  h_addr    = '0;
    logic [15:0] h_data    = '0;
    logic [19:0] h_left    = '0;
    logic [19:0] h_right   = '0;
    logic [9:0]  h_req     = 10'h3FF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Lock follows from rise spacing: consecutive rises exactly one frame apart.
    task automatic model_step(input bit s);
        if (!ac97_rst_b) begin
            prev_sync = 0;
        end else begin
            if (s && !prev_sync) begin
                if (m_locked) begin
                    if (!(have_last && (cyc - last_rise == 256))) begin
                        m_locked  = 0;
                        run       = 1;
                        frame_err = 1;
                        exp_err_cnt++;
                    end
                end else begin
                    if (have_last && run > 0 && (cyc - last_rise == 256)) run++;
                    else run = 1;
                    if (run >= LOCK_FRAMES) m_locked = 1;
                end
                last_rise = cyc;
                have_last = 1;
            end
            prev_sync = s;
        end
        cyc++;
    endtask

    task automatic model_reset();
        m_locked  = 0;
        run       = 0;
        have_last = 0;
        prev_sync = 0;
        h_addr    = '0;
        h_data    = '0;
        h_left    = '0;
        h_right   = '0;
        h_req     = 10'h3FF;
    endtask

    task automatic check_all_zero();
        check("rst_locked", locked, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_frame_strobe", frame_strobe, 0);
        check("rst_codec_ready", codec_ready, 0);
        check("rst_tag_valid", tag_valid, 0);
        check("rst_status_valid", status_valid, 0);
        check("rst_status_addr", status_addr, 0);
        check("rst_status_data", status_data, 0);
        check("rst_pcm_valid", pcm_valid, 0);
        check("rst_pcm_left", pcm_left, 0);
        check("rst_pcm_right", pcm_right, 0);
`ifdef AC97_RX_SLOTREQ_EN
        check("rst_slot_req", slot_req, 10'h3FF);
`endif
    endtask

    // Drive one 256-bit frame; sync is high from bit 254 through bit 13 of the next frame.
    task automatic send_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                              input logic [19:0] s3, input logic [19:0] s4,
                              input int inject_at, input int rst_at);
        logic [19:0] sl [4];
        bit          start_locked;
        bit          s;
        logic        bitv;
        exp_t        e;
        sl[0] = s1; sl[1] = s2; sl[2] = s3; sl[3] = s4;
        start_locked = m_locked;
        frame_err    = 0;
        for (int b = 0; b < 256; b++) begin
            @(posedge ac97_bitclk);
            #1;
            if (b == 0) check("locked_at_frame_start", locked, m_locked);
            if (inject_at >= 0 && b == inject_at + 1) begin
                check("sync_err_pulse", sync_err, 1);
                check("locked_drop_on_err", locked, 0);
            end
            if (inject_at >= 0 && b == inject_at + 2) check("sync_err_width", sync_err, 0);
            if (rst_at >= 0 && b == rst_at) begin
                ac97_rst_b = 1'b0;
                #1;
                check_all_zero();
                model_reset();
                start_locked = 0;
            end
            if (rst_at >= 0 && b == rst_at + 10) ac97_rst_b = 1'b1;
            if (b < 16)      bitv = tag[15 - b];
            else if (b < 96) bitv = sl[(b - 16) / 20][19 - ((b - 16) % 20)];
            else             bitv = 1'($urandom);
            s = (b >= 254) || (b <= 13) || (b == inject_at);
            ac97_sdata_in = bitv;
            ac97_sync     = s;
            model_step(s);
            if (b == 255 && start_locked && !frame_err) begin
                e.codec_ready  = tag[15];
                e.tag_valid    = tag[14:3];
                e.status_valid = tag[14] & tag[13];
                e.pcm_valid    = tag[12] & tag[11];
                if (e.status_valid) begin
                    h_addr = s1[18:12];
                    h_data = s2[19:4];
                end
                if (e.pcm_valid) begin
                    h_left  = s3;
                    h_right = s4;
                end
                if (tag[14]) h_req = s1[11:2];
                e.status_addr = h_addr;
                e.status_data = h_data;
                e.pcm_left    = h_left;
                e.pcm_right   = h_right;
                e.slot_req    = h_req;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++)
            send_frame(16'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), -1, -1);
    endtask

    // Monitor: every strobe must match the oldest expected frame; pulses never appear alone.
    always @(negedge ac97_bitclk) begin
        if (sync_err) seen_err_cnt++;
        if (frame_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_strobe actual=1 required=0");
            end else begin
                mon_e = exp_q.pop_front();
                check("codec_ready", codec_ready, mon_e.codec_ready);
                check("tag_valid", tag_valid, mon_e.tag_valid);
                check("status_valid", status_valid, mon_e.status_valid);
                check("status_addr", status_addr, mon_e.status_addr);
                check("status_data", status_data, mon_e.status_data);
                check("pcm_valid", pcm_valid, mon_e.pcm_valid);
                check("pcm_left", pcm_left, mon_e.pcm_left);
                check("pcm_right", pcm_right, mon_e.pcm_right);
`ifdef AC97_RX_SLOTREQ_EN
                check("slot_req", slot_req, mon_e.slot_req);
`endif
            end
        end else if (status_valid || pcm_valid) begin
            checks++;
            failures++;
            $display("FAIL pulse_without_strobe actual=%0b%0b required=00", status_valid, pcm_valid);
        end
    end

    initial begin
        ac97_rst_b    = 1'b0;
        ac97_sdata_in = 1'b0;
        ac97_sync     = 1'b0;
        repeat (3) @(posedge ac97_bitclk);
        #1;
        check_all_zero();
        ac97_rst_b = 1'b1;

        // Acquire lock on a clean grid; the first two frames are never published.
        send_random(2);
        send_frame(16'hE000, 20'h26000, 20'h000F0, 20'($urandom), 20'($urandom), -1, -1);
        send_frame(16'h9800, 20'($urandom), 20'($urandom), 20'h12340, 20'hFEDC0, -1, -1);
        send_frame(16'hC000, 20'h00FFC, 20'($urandom), 20'($urandom), 20'($urandom), -1, -1);
        send_frame(16'hC000, 20'h00000, 20'($urandom), 20'($urandom), 20'($urandom), -1, -1);
        send_frame(16'hFFF8, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), -1, -1);
        send_random(4);

        // Off-grid sync rise while locked, then relock.
        send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), 100, -1);
        send_random(4);

        // Reset mid-frame, then relock from scratch.
        send_frame(16'hF800, 20'($urandom), 20'($urandom), 20'($urandom), 20'($urandom), -1, 60);
        send_random(5);

        @(posedge ac97_bitclk);
        #1;
        ac97_sync     = 1'b0;
        ac97_sdata_in = 1'b0;
        repeat (4) @(posedge ac97_bitclk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 0);
        check("sync_err_count", 64'(seen_err_cnt), 64'(exp_err_cnt));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
